pos_pid: RTL and testbench
==========================

// Module: pos_pid
// PURPOSE
//  Free-running discrete PID controller for the galvo position loop. Every clk_pid
//  cycle it samples the target and measured ADC position and forms error, integral
//  and derivative terms. It outputs a gain-weighted, saturated DAC drive word.
//  Sits between the ADC/SPI front end and the galvo DAC driver; gains and limits
//  are quasi-static register inputs.
// PARAMETERS
//  GAIN_SHIFT  10  gains are unsigned fixed point with GAIN_SHIFT fraction bits (1024 = 1.0)
// PORTS
//  clk_pid           in   1   sole clock; all state on rising edge
//  sys_rstn          in   1   reset: one clock; asynchronous, active-low
//  kp                in   16  proportional gain, unsigned
//  ki                in   16  integral gain, unsigned
//  kd                in   16  derivative gain, unsigned
//  dac_limit         in   16  unsigned output magnitude limit; values >32767 treated as 32767
//  pid_i_saturation  in   24  unsigned integral-accumulator magnitude limit; >8388607 -> 8388607
//  pos_target        in   16  target position, unsigned
//  pos_adc           in   16  measured position, unsigned
//  pos_dac           out  16  drive word, signed two's complement, |pos_dac| <= dac_limit
// BEHAVIOUR
//  - No handshake: inputs are sampled on every clock edge; the loop rate is clk_pid.
//  - Reset (sys_rstn=0, async): every register is cleared, including e_r, e_prev,
//    integ, deriv, products and pos_dac. pos_dac=0 while in reset and until the
//    pipeline refills.
//  - Pipeline stage 1: e_r <= $signed({1'b0,pos_target}) - $signed({1'b0,pos_adc});
//    17-bit signed.
//  - Stage 2:
//    - integ <= clamp(integ + e_r, -SAT, +SAT); 24-bit signed.
//    - The sum is computed at 25 bits before clamping, so there is no wrap.
//    - deriv <= e_r - e_prev; 18-bit signed.
//    - e_prev <= e_r; pe <= e_r.
//    - After reset e_prev=0, so the first derivative equals the first error.
//  - Stage 3 products, gains zero-extended:
//    - P = kp*pe   (34b signed)
//    - I = ki*integ (41b signed)
//    - D = kd*deriv (35b signed)
//  - Stage 4:
//    - s = P + I + D, at 42 bits signed.
//    - q = s >>> GAIN_SHIFT (arithmetic shift, floor rounding).
//    - pos_dac <= clamp(q, -LIM, +LIM).
//  - Latency: an input change is first visible on pos_dac 4 rising edges after it is sampled.
//  - Throughput: one result per cycle.
//  - Limits:
//    - Changes to dac_limit or pid_i_saturation act on the next computation; no reset is needed.
//    - Lowering SAT below |integ| clamps integ on its next update.
//  - Boundaries:
//    - dac_limit=0 -> pos_dac=0.
//    - pid_i_saturation=0 -> integ held at 0.
//    - Maximum error is +-65535, with no overflow at any stage.
//  - Reset mid-operation clears all state immediately. The output restarts from 0
//    with an empty integrator.
// STRUCTURE
//  - Shared package galvo_pkg holds:
//    - DAC_W=16, ADC_W=16, GAIN_W=16, INTEG_W=24
//    - a signed saturate function sat(val, lim)
//  - One natural sub-module, pid_sat, a combinational symmetric clamp. It is used twice:
//    integrator and output.
//  - Everything else is inline in pos_pid.
// TESTING
//  1. Reset: hold sys_rstn=0 with target=10000, adc=0 -> pos_dac=0 throughout.
//     Release -> pos_dac nonzero only from the 4th edge on.
//  2. Proportional: kp=1024, ki=kd=0, dac_limit=5000, target=1000, adc=0 -> pos_dac=1000.
//     Then adc=4000 -> pos_dac=-3000.
//  3. Output clamp: kp=1200, ki=kd=0, dac_limit=5000, target=10000, adc=0 -> raw 11718
//     -> pos_dac=5000. Swap target and adc -> pos_dac=-5000.
//  4. Integral saturation: kp=kd=0, ki=1024, pid_i_saturation=50, dac_limit=5000,
//     target=10, adc=0 -> pos_dac steps 10,20,30,40,50 and then holds at 50.
//  5. Derivative: kp=ki=0, kd=1024, error steps 0 -> 100 -> 100 -> pos_dac shows a
//     one-cycle 100 pulse, then returns to 0.
//  6. Ramp: kp=1200, ki=60, kd=1200, dac_limit=5000, sat=5000, target=10000, adc+=100 every
//     2 cycles -> pos_dac always within +-5000; saturates at +5000 early, goes negative
//     once adc>target, ends at -5000.

Source files
------------

// File: rtl/galvo_pkg.sv
// rtl/galvo_pkg.sv - shared widths and symmetric saturate helper for the galvo position loop
package galvo_pkg;

   localparam int DAC_W   = 16;
   localparam int ADC_W   = 16;
   localparam int GAIN_W  = 16;
   localparam int INTEG_W = 24;
   localparam int SAT_W   = 42;

   // Clamp val into [-lim, +lim]; lim is expected to be non-negative.
   function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] val,
                                                   input logic signed [SAT_W-1:0] lim);
      if (val > lim)
         return lim;
      else if (val < -lim)
         return -lim;
      else
         return val;
   endfunction

endpackage

// File: rtl/pid_sat.sv
// rtl/pid_sat.sv - combinational symmetric clamp, W-bit signed in, OW-bit signed out
module pid_sat
   import galvo_pkg::*;
#(
   parameter int W  = 25,
   parameter int OW = 24
) (
   input  logic signed [W-1:0]  val,
   input  logic        [W-1:0]  lim,
   output logic signed [OW-1:0] res
);

   // lim must fit in OW-1 magnitude bits, so truncating the clamped value is lossless.
   assign res = OW'(sat(SAT_W'(val), SAT_W'(lim)));

endmodule

// File: rtl/pos_pid.sv
// rtl/pos_pid.sv - free-running four-stage PID controller driving the galvo DAC
module pos_pid
   import galvo_pkg::*;
#(
   parameter int GAIN_SHIFT = 10
) (
   input  logic                clk_pid,
   input  logic                sys_rstn,
   input  logic [GAIN_W-1:0]   kp,
   input  logic [GAIN_W-1:0]   ki,
   input  logic [GAIN_W-1:0]   kd,
   input  logic [DAC_W-1:0]    dac_limit,
   input  logic [INTEG_W-1:0]  pid_i_saturation,
   input  logic [ADC_W-1:0]    pos_target,
   input  logic [ADC_W-1:0]    pos_adc,
   output logic [DAC_W-1:0]    pos_dac
);

   localparam int ERR_W = ADC_W + 1;
   localparam int DER_W = ADC_W + 2;
   localparam int P_W   = GAIN_W + 1 + ERR_W;
   localparam int I_W   = GAIN_W + 1 + INTEG_W;
   localparam int D_W   = GAIN_W + 1 + DER_W;
   localparam int Q_W   = SAT_W - GAIN_SHIFT;

   localparam logic [INTEG_W-1:0] INTEG_MAX = {1'b0, {(INTEG_W-1){1'b1}}};
   localparam logic [DAC_W-1:0]   DAC_MAX   = {1'b0, {(DAC_W-1){1'b1}}};

   logic signed [ERR_W-1:0]   e_r, e_prev, pe;
   logic signed [INTEG_W-1:0] integ, integ_nxt;
   logic signed [DER_W-1:0]   deriv;
   logic signed [P_W-1:0]     p_r;
   logic signed [I_W-1:0]     i_r;
   logic signed [D_W-1:0]     d_r;
   logic signed [INTEG_W:0]   integ_sum;
   logic        [INTEG_W:0]   sat_lim;
   logic        [Q_W-1:0]     dac_lim;
   logic signed [SAT_W-1:0]   s_sum;
   logic signed [Q_W-1:0]     q;
   logic signed [DAC_W-1:0]   dac_nxt;

   // Out-of-range limits collapse to the largest magnitude the signed widths can hold.
   assign sat_lim = (pid_i_saturation > INTEG_MAX) ? (INTEG_W+1)'(INTEG_MAX)
                                                   : (INTEG_W+1)'(pid_i_saturation);
   assign dac_lim = (dac_limit > DAC_MAX) ? Q_W'(DAC_MAX) : Q_W'(dac_limit);

   assign integ_sum = (INTEG_W+1)'(integ) + (INTEG_W+1)'(e_r);

   pid_sat #(.W(INTEG_W+1), .OW(INTEG_W)) u_integ_sat (
      .val (integ_sum),
      .lim (sat_lim),
      .res (integ_nxt)
   );

   assign s_sum = SAT_W'(p_r) + SAT_W'(i_r) + SAT_W'(d_r);
   assign q     = Q_W'(s_sum >>> GAIN_SHIFT);

   pid_sat #(.W(Q_W), .OW(DAC_W)) u_dac_sat (
      .val (q),
      .lim (dac_lim),
      .res (dac_nxt)
   );

   always_ff @(posedge clk_pid or negedge sys_rstn) begin
      if (!sys_rstn) begin
         e_r     <= '0;
         e_prev  <= '0;
         pe      <= '0;
         integ   <= '0;
         deriv   <= '0;
         p_r     <= '0;
         i_r     <= '0;
         d_r     <= '0;
         pos_dac <= '0;
      end else begin
         e_r     <= $signed({1'b0, pos_target}) - $signed({1'b0, pos_adc});
         integ   <= integ_nxt;
         deriv   <= DER_W'(e_r) - DER_W'(e_prev);
         e_prev  <= e_r;
         pe      <= e_r;
         p_r     <= $signed({1'b0, kp}) * pe;
         i_r     <= $signed({1'b0, ki}) * integ;
         d_r     <= $signed({1'b0, kd}) * deriv;
         pos_dac <= dac_nxt;
      end
   end

endmodule

// File: tb/tb_pos_pid.sv
// tb/tb_pos_pid.sv - randomized and directed self-checking bench for pos_pid
module tb_pos_pid;

   logic        clk_pid = 1'b0;
   logic        sys_rstn = 1'b0;
   logic [15:0] kp = '0, ki = '0, kd = '0, dac_limit = '0;
   logic [23:0] pid_i_saturation = '0;
   logic [15:0] pos_target = '0, pos_adc = '0;
   logic [15:0] pos_dac;

   int     n_cmp = 0;
   int     n_bad = 0;
   longint m_integ = 0;
   longint m_eprev = 0;
   longint hist[$];
   longint last_dac = 0;

   pos_pid dut (
      .clk_pid          (clk_pid),
      .sys_rstn         (sys_rstn),
      .kp               (kp),
      .ki               (ki),
      .kd               (kd),
      .dac_limit        (dac_limit),
      .pid_i_saturation (pid_i_saturation),
      .pos_target       (pos_target),
      .pos_adc          (pos_adc),
      .pos_dac          (pos_dac)
   );

   always #5 clk_pid = ~clk_pid;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint clampl(input longint v, input longint l);
      return (v > l) ? l : ((v < -l) ? -l : v);
   endfunction

   // One loop iteration of the textbook controller, evaluated on today's inputs.
   function automatic longint model_step();
      longint e, d, s, sat_m, lim_m;
      e     = longint'(pos_target) - longint'(pos_adc);
      sat_m = (pid_i_saturation > 24'd8388607) ? 8388607 : longint'(pid_i_saturation);
      lim_m = (dac_limit > 16'd32767) ? 32767 : longint'(dac_limit);
      m_integ = clampl(m_integ + e, sat_m);
      d       = e - m_eprev;
      m_eprev = e;
      s = longint'(kp) * e + longint'(ki) * m_integ + longint'(kd) * d;
      return clampl(s / 1024 - ((s % 1024 != 0 && s < 0) ? 1 : 0), lim_m);
   endfunction

   task automatic step(input string tag);
      longint exp;
      @(posedge clk_pid);
      hist.push_back(model_step());
      exp = hist.pop_front();
      @(negedge clk_pid);
      last_dac = longint'($signed(pos_dac));
      check(tag, last_dac, exp);
   endtask

   task automatic do_reset();
      sys_rstn = 1'b0;
      #1;
      check("rst_async", longint'($signed(pos_dac)), 0);
      repeat (2) begin
         @(negedge clk_pid);
         check("rst_hold", longint'($signed(pos_dac)), 0);
      end
      sys_rstn = 1'b1;
      m_integ  = 0;
      m_eprev  = 0;
      hist     = '{0, 0, 0};
   endtask

   task automatic cfg(input logic [15:0] p, input logic [15:0] i, input logic [15:0] d,
                      input logic [15:0] lim, input logic [23:0] sat);
      kp = p; ki = i; kd = d; dac_limit = lim; pid_i_saturation = sat;
   endtask

   initial begin
      bit seen_pos, seen_neg;

      // reset held with a large error, then latency of the refill
      cfg(16'd1024, 16'd0, 16'd0, 16'd20000, 24'd0);
      pos_target = 16'd10000; pos_adc = 16'd0;
      repeat (4) begin
         @(negedge clk_pid);
         check("t1_in_reset", longint'($signed(pos_dac)), 0);
      end
      sys_rstn = 1'b1;
      m_integ = 0; m_eprev = 0; hist = '{0, 0, 0};
      for (int k = 1; k <= 3; k++) begin
         step("t1_model");
         check("t1_early_zero", last_dac, 0);
      end
      step("t1_model");
      check("t1_fourth_edge", last_dac, 10000);

      // proportional only
      @(negedge clk_pid);
      cfg(16'd1024, 16'd0, 16'd0, 16'd5000, 24'd0);
      pos_target = 16'd1000; pos_adc = 16'd0;
      do_reset();
      repeat (6) step("t2_model");
      check("t2_p_pos", last_dac, 1000);
      pos_adc = 16'd4000;
      repeat (5) step("t2_model");
      check("t2_p_neg", last_dac, -3000);

      // output clamp both signs
      cfg(16'd1200, 16'd0, 16'd0, 16'd5000, 24'd0);
      pos_target = 16'd10000; pos_adc = 16'd0;
      do_reset();
      repeat (6) step("t3_model");
      check("t3_clamp_pos", last_dac, 5000);
      pos_target = 16'd0; pos_adc = 16'd10000;
      repeat (5) step("t3_model");
      check("t3_clamp_neg", last_dac, -5000);

      // integrator saturation staircase
      cfg(16'd0, 16'd1024, 16'd0, 16'd5000, 24'd50);
      pos_target = 16'd10; pos_adc = 16'd0;
      do_reset();
      repeat (3) step("t4_model");
      for (int k = 1; k <= 8; k++) begin
         step("t4_model");
         check("t4_integ_step", last_dac, (k < 5) ? 10 * k : 50);
      end

      // derivative pulse
      cfg(16'd0, 16'd0, 16'd1024, 16'd5000, 24'd1000);
      pos_target = 16'd0; pos_adc = 16'd0;
      do_reset();
      repeat (4) step("t5_model");
      pos_target = 16'd100;
      repeat (3) step("t5_model");
      step("t5_model");
      check("t5_pulse", last_dac, 100);
      step("t5_model");
      check("t5_after_pulse", last_dac, 0);
      step("t5_model");
      check("t5_settled", last_dac, 0);

      // ramp through the target
      cfg(16'd1200, 16'd60, 16'd1200, 16'd5000, 24'd5000);
      pos_target = 16'd10000; pos_adc = 16'd0;
      do_reset();
      seen_pos = 1'b0; seen_neg = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step("t6_model");
         check("t6_bound", longint'(last_dac <= 5000 && last_dac >= -5000), 1);
         if (last_dac == 5000 && i < 40) seen_pos = 1'b1;
         if (last_dac < 0) seen_neg = 1'b1;
         if (i % 2 == 1) pos_adc = pos_adc + 16'd100;
      end
      check("t6_early_sat", longint'(seen_pos), 1);
      check("t6_went_neg", longint'(seen_neg), 1);
      check("t6_final", last_dac, -5000);

      // randomized segments, each started by a mid-operation reset
      for (int seg = 0; seg < 25; seg++) begin
         kp = 16'($urandom); ki = 16'($urandom); kd = 16'($urandom);
         case ($urandom_range(0, 3))
            0: dac_limit = 16'd0;
            1: dac_limit = 16'hFFFF;
            default: dac_limit = 16'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0: pid_i_saturation = 24'd0;
            1: pid_i_saturation = 24'hFFFFFF;
            2: pid_i_saturation = 24'($urandom_range(0, 100000));
            default: pid_i_saturation = 24'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0) begin
            kp = kp >> 6; ki = ki >> 10; kd = kd >> 6;
         end
         do_reset();
         for (int c = 0; c < 40; c++) begin
            case ($urandom_range(0, 7))
               0: begin pos_target = 16'hFFFF; pos_adc = 16'h0000; end
               1: begin pos_target = 16'h0000; pos_adc = 16'hFFFF; end
               default: begin pos_target = 16'($urandom); pos_adc = 16'($urandom); end
            endcase
            step("rand_model");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
